// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and FSM states
// for the SRAM slave and its byte-lane decoder.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Byte-lane enable decode from HSIZE/HADDR[1:0]
// plus size/alignment legality check.
module ahb_byte_lane_dec
  import ahb_sram_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_be,
  output logic       o_err
);

  // Lane select and error flag for one transfer
  always_comb begin
    o_be  = 4'b0000;
    o_err = 1'b0;
    unique case (1'b1)
      (i_size == HSIZE_BYTE): begin
        o_be = 4'b0001 << i_addr;
      end
      (i_size == HSIZE_HALF): begin
        o_be  = i_addr[1] ? 4'b1100 : 4'b0011;
        o_err = i_addr[0];
      end
      (i_size == HSIZE_WORD): begin
        o_be  = 4'b1111;
        o_err = |i_addr;
      end
      default: begin
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a synchronous SRAM
// with programmable wait states and error response.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [3:0]            ram_byte_en,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  state_e                r_state;
  state_e                w_state_n;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_n;
  logic                  r_first;
  logic                  w_first_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic                  r_cap;
  logic [31:0]           r_hrdata;

  logic [3:0]            w_be;
  logic                  w_err;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_ready;
  logic                  w_resp;
  logic                  w_ren;
  logic                  w_wen;
  logic                  w_unused;

  assign w_unused = ^HADDR[31:ADDR_WIDTH+2];

  ahb_byte_lane_dec u_dec (
    .i_size (HSIZE),
    .i_addr (HADDR[1:0]),
    .o_be   (w_be),
    .o_err  (w_err)
  );

  // Next state, counter and bus/RAM strobes
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_first_n = r_first;
    w_done    = 1'b0;
    w_accept  = 1'b0;
    w_ready   = 1'b1;
    w_resp    = 1'b0;
    w_ren     = 1'b0;
    w_wen     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_done = 1'b1;
      end
      ST_READ: begin
        if (r_first) begin
          w_ren     = 1'b1;
          w_ready   = 1'b0;
          w_first_n = 1'b0;
        end else if (r_cnt != 3'd0) begin
          w_ready = 1'b0;
          w_cnt_n = r_cnt - 3'd1;
        end else begin
          w_done = 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_cnt != 3'd0) begin
          w_ready = 1'b0;
          w_cnt_n = r_cnt - 3'd1;
        end else begin
          w_wen  = 1'b1;
          w_done = 1'b1;
        end
      end
      ST_ERROR: begin
        w_resp = 1'b1;
        if (r_first) begin
          w_ready   = 1'b0;
          w_first_n = 1'b0;
        end else begin
          w_done = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    w_accept = w_done && HSEL && HREADY &&
               (HTRANS == HTRANS_NONSEQ ||
                HTRANS == HTRANS_SEQ);
    if (w_done) begin
      w_state_n = ST_IDLE;
      if (w_accept) begin
        w_first_n = 1'b1;
        w_cnt_n   = 3'(WAIT_STATES);
        if (w_err) begin
          w_state_n = ST_ERROR;
        end else if (HWRITE) begin
          w_state_n = ST_WRITE;
        end else begin
          w_state_n = ST_READ;
        end
      end
    end
  end

  // FSM, wait counter and phase flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_first <= w_first_n;
    end
  end

  // Address-phase capture and read-data hold
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_cap    <= 1'b0;
      r_hrdata <= 32'd0;
    end else begin
      r_cap <= w_ren;
      if (r_cap) begin
        r_hrdata <= ram_rdata;
      end
      if (w_accept && !w_err) begin
        r_addr <= HADDR[ADDR_WIDTH+1:2];
        r_be   <= w_be;
      end
    end
  end

  assign HREADYOUT   = w_ready;
  assign HRESP       = w_resp;
  assign ram_ren     = w_ren;
  assign ram_wen     = w_wen;
  assign ram_addr    = (w_ren | w_wen) ? r_addr : '0;
  assign ram_byte_en = (w_ren | w_wen) ? r_be : 4'b0000;
  assign ram_wdata   = w_wen ? HWDATA : 32'd0;
  assign HRDATA      = r_cap ? ram_rdata : r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances
// (WAIT_STATES=1 and 0) against a transfer model.
module tb_ahb_sram_slave;

  localparam int AW = 14;

  typedef struct packed {
    logic          rdy;
    logic          resp;
    logic          ren;
    logic          wen;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        sel [2];
  logic [31:0] adr [2];
  logic [1:0]  trn [2];
  logic        wr  [2];
  logic [2:0]  siz [2];
  logic [31:0] wd  [2];

  logic          rdy0, resp0, ren0, wen0;
  logic          rdy1, resp1, ren1, wen1;
  logic [AW-1:0] addr0, addr1;
  logic [3:0]    be0, be1;
  logic [31:0]   wdata0, wdata1;
  logic [31:0]   hrdata0, hrdata1;
  logic [31:0]   rd0, rd1;
  logic [31:0]   sram0 [256];
  logic [31:0]   sram1 [256];

  int n_checks = 0;
  int n_err = 0;

  int          kind [2] = '{0, 0};
  int          kk   [2] = '{0, 0};
  logic [13:0] p_addr [2];
  logic [3:0]  p_be   [2];
  logic [31:0] mm [2][256];
  int          stall_run  [2] = '{0, 0};
  int          last_stall [2] = '{0, 0};
  int          wen_cnt    [2] = '{0, 0};
  int          ren_cnt    [2] = '{0, 0};
  logic [3:0]  last_wbe   [2];
  logic [13:0] last_waddr [2];
  logic [31:0] last_rdata [2];
  logic        last_resp  [2];

  obs_t obs0, obs1;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_dut0 (
    .CLK(clk), .nRST(rst_n),
    .HSEL(sel[0]), .HADDR(adr[0]), .HTRANS(trn[0]),
    .HWRITE(wr[0]), .HSIZE(siz[0]), .HWDATA(wd[0]),
    .HREADY(rdy0), .HRDATA(hrdata0),
    .HREADYOUT(rdy0), .HRESP(resp0),
    .ram_addr(addr0), .ram_ren(ren0), .ram_wen(wen0),
    .ram_byte_en(be0), .ram_wdata(wdata0),
    .ram_rdata(rd0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut1 (
    .CLK(clk), .nRST(rst_n),
    .HSEL(sel[1]), .HADDR(adr[1]), .HTRANS(trn[1]),
    .HWRITE(wr[1]), .HSIZE(siz[1]), .HWDATA(wd[1]),
    .HREADY(rdy1), .HRDATA(hrdata1),
    .HREADYOUT(rdy1), .HRESP(resp1),
    .ram_addr(addr1), .ram_ren(ren1), .ram_wen(wen1),
    .ram_byte_en(be1), .ram_wdata(wdata1),
    .ram_rdata(rd1)
  );

  // Synchronous SRAMs behind each slave
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen0 && be0[i]) sram0[addr0[7:0]][8*i +: 8] <= wdata0[8*i +: 8];
      if (wen1 && be1[i]) sram1[addr1[7:0]][8*i +: 8] <= wdata1[8*i +: 8];
    end
    if (ren0) rd0 <= sram0[addr0[7:0]];
    if (ren1) rd1 <= sram1[addr1[7:0]];
  end

  assign obs0 = '{rdy:rdy0, resp:resp0, ren:ren0, wen:wen0,
                  addr:addr0, be:be0, wdata:wdata0, rdata:hrdata0};
  assign obs1 = '{rdy:rdy1, resp:resp1, ren:ren1, wen:wen1,
                  addr:addr1, be:be1, wdata:wdata1, rdata:hrdata1};

  task automatic chk(input int d, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %h expected %h @%0t",
               d, nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  // Per-cycle model: data-phase cycle index k decides outputs
  task automatic do_dut(input int d, input obs_t o);
    int   ws;
    logic e_rdy, e_resp, e_ren, e_wen, err;
    logic [31:0] a;
    ws = (d == 0) ? 1 : 0;
    if (!rst_n) begin
      chk(d, "rst_rdy",   32'(o.rdy),   32'd1);
      chk(d, "rst_resp",  32'(o.resp),  32'd0);
      chk(d, "rst_ren",   32'(o.ren),   32'd0);
      chk(d, "rst_wen",   32'(o.wen),   32'd0);
      chk(d, "rst_addr",  32'(o.addr),  32'd0);
      chk(d, "rst_be",    32'(o.be),    32'd0);
      chk(d, "rst_wdata", o.wdata,      32'd0);
      chk(d, "rst_rdata", o.rdata,      32'd0);
      kind[d] = 0;
      kk[d] = 0;
      stall_run[d] = 0;
      return;
    end
    e_rdy = 1'b1; e_resp = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
    case (kind[d])
      1: begin e_ren = (kk[d] == 1); e_rdy = (kk[d] == ws + 2); end
      2: begin e_rdy = (kk[d] == ws + 1); e_wen = e_rdy; end
      3: begin e_resp = 1'b1; e_rdy = (kk[d] == 2); end
      default: ;
    endcase
    chk(d, "hreadyout", 32'(o.rdy),  32'(e_rdy));
    chk(d, "hresp",     32'(o.resp), 32'(e_resp));
    chk(d, "ram_ren",   32'(o.ren),  32'(e_ren));
    chk(d, "ram_wen",   32'(o.wen),  32'(e_wen));
    if (e_ren || e_wen) begin
      chk(d, "ram_addr",    32'(o.addr), 32'(p_addr[d]));
      chk(d, "ram_byte_en", 32'(o.be),   32'(p_be[d]));
    end
    if (e_wen) begin
      chk(d, "ram_wdata", o.wdata, wd[d]);
      for (int i = 0; i < 4; i++)
        if (p_be[d][i]) mm[d][p_addr[d][7:0]][8*i +: 8] = wd[d][8*i +: 8];
    end
    if (kind[d] == 1 && e_rdy)
      chk(d, "hrdata", o.rdata, mm[d][p_addr[d][7:0]]);
    if (o.wen) begin
      wen_cnt[d]++;
      last_wbe[d] = o.be;
      last_waddr[d] = o.addr;
    end
    if (o.ren) ren_cnt[d]++;
    if (o.rdy) begin
      last_stall[d] = stall_run[d];
      stall_run[d] = 0;
      last_rdata[d] = o.rdata;
      last_resp[d] = o.resp;
    end else begin
      stall_run[d]++;
    end
    if (kind[d] != 0 && !e_rdy) begin
      kk[d]++;
    end else if (sel[d] && trn[d][1]) begin
      a = adr[d];
      err = (siz[d] > 3'd2) || (siz[d] == 3'd1 && a[0]) ||
            (siz[d] == 3'd2 && a[1:0] != 2'b00);
      kind[d] = err ? 3 : (wr[d] ? 2 : 1);
      kk[d] = 1;
      p_addr[d] = a[15:2];
      case (siz[d])
        3'd0: p_be[d] = 4'b0001 << a[1:0];
        3'd1: p_be[d] = a[1] ? 4'b1100 : 4'b0011;
        default: p_be[d] = 4'b1111;
      endcase
    end else begin
      kind[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    do_dut(0, obs0);
    do_dut(1, obs1);
  end

  // Address phase: hold until accepted, then drive its HWDATA
  task automatic issue(input int d, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] data);
    int n = 0;
    sel[d] = 1'b1; trn[d] = 2'b10; wr[d] = w; siz[d] = sz; adr[d] = a;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_of(d) && n < 20);
    if (!rdy_of(d)) begin
      n_checks++; n_err++;
      $display("FAIL dut%0d accept_timeout: got 0 expected 1", d);
    end
    @(posedge clk); #1;
    wd[d] = data;
  endtask

  task automatic idle_wait(input int d);
    int n = 0;
    sel[d] = 1'b0; trn[d] = 2'b00;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_of(d) && n < 20);
    if (!rdy_of(d)) begin
      n_checks++; n_err++;
      $display("FAIL dut%0d done_timeout: got 0 expected 1", d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; adr[d] = 32'd0; trn[d] = 2'b00;
      wr[d] = 1'b0; siz[d] = 3'd0; wd[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(0, "lit_rst_rdy",   32'(rdy0),  32'd1);
    chk(0, "lit_rst_resp",  32'(resp0), 32'd0);
    chk(0, "lit_rst_rdata", hrdata0,    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    idle_wait(0);
    chk(0, "lit_wr_stall", 32'(last_stall[0]), 32'd1);
    chk(0, "lit_wr_be",    32'(last_wbe[0]),   32'hF);

    issue(0, 1'b0, 3'd2, 32'h10, 32'd0);
    idle_wait(0);
    chk(0, "lit_rd_stall", 32'(last_stall[0]), 32'd2);
    chk(0, "lit_rd_data",  last_rdata[0],      32'hDEADBEEF);

    base = wen_cnt[0];
    issue(0, 1'b1, 3'd0, 32'h13, 32'hAB000000);
    idle_wait(0);
    chk(0, "lit_byte_be",   32'(last_wbe[0]),   32'h8);
    chk(0, "lit_byte_addr", 32'(last_waddr[0]), 32'h4);
    chk(0, "lit_byte_wen",  32'(wen_cnt[0] - base), 32'd1);

    issue(0, 1'b0, 3'd2, 32'h10, 32'd0);
    idle_wait(0);
    chk(0, "lit_merge_data", last_rdata[0], 32'hABADBEEF);

    base = ren_cnt[0];
    issue(0, 1'b0, 3'd1, 32'h21, 32'd0);
    idle_wait(0);
    chk(0, "lit_err_resp",  32'(last_resp[0]),  32'd1);
    chk(0, "lit_err_stall", 32'(last_stall[0]), 32'd1);
    chk(0, "lit_err_noren", 32'(ren_cnt[0] - base), 32'd0);

    base = ren_cnt[0] + wen_cnt[0];
    sel[0] = 1'b1; trn[0] = 2'b00;
    repeat (5) @(negedge clk);
    chk(0, "lit_idle_strobes", 32'(ren_cnt[0] + wen_cnt[0] - base), 32'd0);
    chk(0, "lit_idle_stall",   32'(stall_run[0]), 32'd0);
    @(posedge clk); #1;
    sel[0] = 1'b0;

    issue(0, 1'b1, 3'd2, 32'h40, 32'h12345678);
    issue(0, 1'b0, 3'd2, 32'h40, 32'd0);
    idle_wait(0);
    chk(0, "lit_raw_data", last_rdata[0], 32'h12345678);

    issue(0, 1'b0, 3'd2, 32'h10, 32'd0);
    sel[0] = 1'b0; trn[0] = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    base = wen_cnt[0];
    #1;
    chk(0, "lit_arst_rdy",   32'(rdy0),   32'd1);
    chk(0, "lit_arst_resp",  32'(resp0),  32'd0);
    chk(0, "lit_arst_rdata", hrdata0,     32'd0);
    chk(0, "lit_arst_ren",   32'(ren0),   32'd0);
    chk(0, "lit_arst_wen",   32'(wen0),   32'd0);
    chk(0, "lit_arst_be",    32'(be0),    32'd0);
    chk(0, "lit_arst_addr",  32'(addr0),  32'd0);
    chk(0, "lit_arst_wdata", wdata0,      32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(0, "lit_arst_nowen", 32'(wen_cnt[0] - base), 32'd0);
    @(posedge clk); #1;

    issue(1, 1'b1, 3'd2, 32'h0, 32'hCAFEF00D);
    issue(1, 1'b0, 3'd2, 32'h0, 32'd0);
    chk(1, "lit_ws0_wr_stall", 32'(last_stall[1]), 32'd0);
    idle_wait(1);
    chk(1, "lit_ws0_rd_stall", 32'(last_stall[1]), 32'd1);
    chk(1, "lit_ws0_rd_data",  last_rdata[1],      32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
